// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Decode-stage hazard detection and operand forwarding. It also holds a
// single-entry scoreboard for one non-pipelined long-latency unit (mul/div)
// that has a fixed latency.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   reg_rdata              regfile read data, one DATA_W slice per source
//   de_src_addr            decode source register addresses (ADDR_W per source)
//   de_src_used            source i is really read by the decode instruction
//   de_valid               decode stage holds a valid instruction
//   de_dest_wen            decode instruction writes a register via normal pipe
//   de_long_issue          decode instruction is a long-unit op
//   de_dest_addr           decode destination register
//   exe_* / mem_* / wb_*   in-flight writer info per pipeline stage
//   exe_mem_read           exe-stage instruction is a load
//   lu_wdata               long-unit result, valid when the countdown is at 1
//   de_src_data            forwarded operand per source
//   stall                  hold IF/DE and inject a bubble into EXE
//   long_busy              long unit is counting down
//   long_wb_en             long result writes the regfile this cycle
//   long_wb_addr           long result destination register
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = $clog2(LONG_LAT + 1)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_SRC*DATA_W-1:0]   reg_rdata,
    input  logic [NUM_SRC*ADDR_W-1:0]   de_src_addr,
    input  logic [NUM_SRC-1:0]          de_src_used,
    input  logic                        de_valid,
    input  logic                        de_dest_wen,
    input  logic                        de_long_issue,
    input  logic [ADDR_W-1:0]           de_dest_addr,
    input  logic                        exe_reg_en,
    input  logic [ADDR_W-1:0]           exe_reg_waddr,
    input  logic [DATA_W-1:0]           exe_reg_wdata,
    input  logic                        exe_mem_read,
    input  logic                        mem_reg_en,
    input  logic [ADDR_W-1:0]           mem_reg_waddr,
    input  logic [DATA_W-1:0]           mem_reg_wdata,
    input  logic                        wb_reg_en,
    input  logic [ADDR_W-1:0]           wb_reg_waddr,
    input  logic [DATA_W-1:0]           wb_reg_wdata,
    input  logic [DATA_W-1:0]           lu_wdata,
    output logic [NUM_SRC*DATA_W-1:0]   de_src_data,
    output logic                        stall,
    output logic                        long_busy,
    output logic                        long_wb_en,
    output logic [ADDR_W-1:0]           long_wb_addr
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LONG_LAT);

    // Scoreboard state
    logic               pend_valid_r;
    logic [ADDR_W-1:0]  pend_addr_r;
    logic [CNT_W-1:0]   long_cnt_r;

    logic               cnt_one_s;
    logic               cnt_gt1_s;
    logic               long_fwd_s;
    logic               exe_wr_s;
    logic               mem_wr_s;
    logic               wb_wr_s;
    logic [NUM_SRC-1:0] load_use_vec_s;
    logic [NUM_SRC-1:0] raw_long_vec_s;
    logic               waw_long_s;
    logic               struct_long_s;
    logic               stall_s;
    logic               issue_s;

    assign cnt_one_s  = (long_cnt_r == CNT_ONE);
    assign cnt_gt1_s  = (long_cnt_r > CNT_ONE);
    // Result is on lu_wdata exactly in the last countdown cycle.
    assign long_fwd_s = pend_valid_r & cnt_one_s;

    // A stage is a forwarding candidate only when it writes a non-zero register.
    assign exe_wr_s = exe_reg_en & (exe_reg_waddr != ZERO_ADDR);
    assign mem_wr_s = mem_reg_en & (mem_reg_waddr != ZERO_ADDR);
    assign wb_wr_s  = wb_reg_en  & (wb_reg_waddr  != ZERO_ADDR);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [ADDR_W-1:0] src_addr_s;
        logic              src_nz_s;
        logic              long_hit_s;
        logic              exe_hit_s;
        logic              mem_hit_s;
        logic              wb_hit_s;
        logic [DATA_W-1:0] fwd_data_s;

        assign src_addr_s = de_src_addr[g*ADDR_W +: ADDR_W];
        assign src_nz_s   = (src_addr_s != ZERO_ADDR);
        assign long_hit_s = long_fwd_s & src_nz_s & (src_addr_s == pend_addr_r);
        assign exe_hit_s  = exe_wr_s & (src_addr_s == exe_reg_waddr);
        assign mem_hit_s  = mem_wr_s & (src_addr_s == mem_reg_waddr);
        assign wb_hit_s   = wb_wr_s  & (src_addr_s == wb_reg_waddr);

        // Operand select: the long result wins because the WAW stall makes
        // every exe/mem/wb writer of pend_addr at that point older than it.
        always_comb begin
            if (long_hit_s) begin
                fwd_data_s = lu_wdata;
            end else if (exe_hit_s) begin
                fwd_data_s = exe_reg_wdata;
            end else if (mem_hit_s) begin
                fwd_data_s = mem_reg_wdata;
            end else if (wb_hit_s) begin
                fwd_data_s = wb_reg_wdata;
            end else begin
                fwd_data_s = reg_rdata[g*DATA_W +: DATA_W];
            end
        end

        assign de_src_data[g*DATA_W +: DATA_W] = fwd_data_s;

        // Unused sources are masked so they never raise a false stall.
        assign load_use_vec_s[g] = de_src_used[g] & exe_mem_read & exe_hit_s;
        assign raw_long_vec_s[g] = de_src_used[g] & pend_valid_r & cnt_gt1_s &
                                   src_nz_s & (src_addr_s == pend_addr_r);
    end

    assign waw_long_s    = de_dest_wen & pend_valid_r & cnt_gt1_s &
                           (de_dest_addr != ZERO_ADDR) & (de_dest_addr == pend_addr_r);
    // At count 1 the old op retires this cycle, so back-to-back issue is allowed.
    assign struct_long_s = de_long_issue & cnt_gt1_s;

    assign stall_s = de_valid & ((|load_use_vec_s) | (|raw_long_vec_s) |
                                 waw_long_s | struct_long_s);
    assign issue_s = de_valid & de_long_issue & ~stall_s;

    // Scoreboard: load on issue, otherwise count down and retire at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= ZERO_ADDR;
            long_cnt_r   <= CNT_ZERO;
        end else if (issue_s) begin
            pend_valid_r <= (de_dest_addr != ZERO_ADDR);
            pend_addr_r  <= de_dest_addr;
            long_cnt_r   <= CNT_LOAD;
        end else if (long_cnt_r != CNT_ZERO) begin
            long_cnt_r <= long_cnt_r - CNT_ONE;
            if (cnt_one_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end else begin
            pend_valid_r <= 1'b0;
        end
    end

    assign stall        = stall_s;
    assign long_busy    = (long_cnt_r != CNT_ZERO);
    assign long_wb_en   = long_fwd_s;
    assign long_wb_addr = pend_addr_r;

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Decode-stage hazard and forwarding unit, parametrised in data width, register-address width and number of source operands.
- Adds a single-entry scoreboard for one non-pipelined long-latency unit (mul/div) with a fixed latency countdown.
- Also adds write-back-stage forwarding, per-source "used" qualifiers that suppress false stalls, WAW and structural stalls, and the long-unit regfile write-back request.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of decode source operands; buses are flattened, source i occupies slice [i*W +: W]
- LONG_LAT, 4, long-unit cycles from issue to result; must be >= 2
- CNT_W, $clog2(LONG_LAT+1), countdown width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- reg_rdata  in  NUM_SRC*DATA_W  regfile read data per source
- de_src_addr  in  NUM_SRC*ADDR_W  decode source register addresses
- de_src_used  in  NUM_SRC  source i is actually read by the decode instruction
- de_valid  in  1  decode holds a valid instruction
- de_dest_wen  in  1  decode instruction writes a register through the normal pipe
- de_long_issue  in  1  decode instruction is a long-unit op
- de_dest_addr  in  ADDR_W  decode destination register
- exe_reg_en, exe_reg_waddr, exe_reg_wdata, exe_mem_read  in  1/ADDR_W/DATA_W/1  exe-stage write info; exe_mem_read marks a load
- mem_reg_en, mem_reg_waddr, mem_reg_wdata  in  1/ADDR_W/DATA_W  mem-stage write info
- wb_reg_en, wb_reg_waddr, wb_reg_wdata  in  1/ADDR_W/DATA_W  wb-stage write info
- lu_wdata  in  DATA_W  long-unit result, valid when long_cnt==1
- de_src_data  out  NUM_SRC*DATA_W  forwarded operand per source
- stall  out  1  hold IF/DE, inject bubble into EXE
- long_busy  out  1  long_cnt != 0
- long_wb_en  out  1  long result writes regfile this cycle
- long_wb_addr  out  ADDR_W  long result destination

Behaviour:
- Reset (resetn low, async): pend_valid=0, pend_addr=0, long_cnt=0. This gives long_busy=0, long_wb_en=0, long_wb_addr=0.
- Register 0 never matches in forwarding, stall or scoreboard logic.
- Forwarding, per source i, purely combinational. Priority:
  1. long result (pend_valid & long_cnt==1 & addr==pend_addr): lu_wdata
  2. exe match: exe_reg_wdata
  3. mem match: mem_reg_wdata
  4. wb match: wb_reg_wdata
  5. otherwise reg_rdata.
  A stage matches when its reg_en=1, waddr!=0 and waddr==src addr.
- The long result has top priority because the WAW stall guarantees any exe/mem/wb writer of pend_addr at long_cnt==1 is older.
- Stall = de_valid & (load_use | raw_long | waw_long | struct_long):
  - load_use: some i with de_src_used[i], exe_mem_read, exe_reg_en, exe_reg_waddr!=0, src addr==exe_reg_waddr.
  - raw_long: some used source equals pend_addr, pend_valid, long_cnt>1.
  - waw_long: de_dest_wen, de_dest_addr==pend_addr!=0, pend_valid, long_cnt>1.
  - struct_long: de_long_issue & long_cnt>1.
- Unused sources (de_src_used[i]=0) never cause a stall.
- Issue fires when de_valid & de_long_issue & ~stall. On issue, next cycle:
  - long_cnt=LONG_LAT.
  - pend_valid=(de_dest_addr!=0), pend_addr=de_dest_addr.
- Counter: when long_cnt!=0 and no issue, decrement by 1. When long_cnt reaches 0, clear pend_valid.
- Issue at long_cnt==1 (back-to-back) is permitted. The old op completes that cycle and the new one reloads the counter and overwrites pend_addr.
- long_wb_en = pend_valid & long_cnt==1; long_wb_addr = pend_addr. Regfile port arbitration is external.
- Dest 0 long op: the unit stays busy for LONG_LAT cycles, with no pending register and no write-back.
- Latency: stall and forwarding are same-cycle combinational. Scoreboard update is visible the cycle after issue.
- Reset mid-operation clears the scoreboard immediately; no write-back follows.

Test Plan:
- Forward priority: exe, mem and wb all write r5 (values 0x11/0x22/0x33), src0=r5 -> de_src_data[0]=0x11. Drop exe_reg_en -> 0x22. Drop mem_reg_en -> 0x33. Drop wb_reg_en -> reg_rdata.
- Load-use: exe_mem_read=1, exe_reg_waddr=r3, src1=r3 used -> stall=1. Same with de_src_used[1]=0 -> stall=0. Same with exe_reg_waddr=0 -> stall=0.
- Long RAW, LONG_LAT=4: issue long to r7, next instruction reads r7 -> stall high while long_cnt=4,3,2. At long_cnt=1, lu_wdata=0xDEAD -> stall=0, de_src_data=0xDEAD, long_wb_en=1, long_wb_addr=7.
- Structural/WAW: while long_cnt=3, de_long_issue=1 -> stall=1. While long_cnt=3, a normal write to r7 (de_dest_wen=1, de_dest_addr=r7) -> stall=1. Same writes to r8 -> no stall. At long_cnt=1, a new long issue to r9 -> accepted; long_cnt=4 and pend_addr=9 next cycle.
- Dest r0 long issue -> long_busy high for 4 cycles, long_wb_en never asserted, a reader of r0 is not stalled.
- Assert resetn low at long_cnt=2 -> long_busy, long_wb_en and stall from the scoreboard all 0 immediately; after release, a reader of the old pend_addr is not stalled.
